knn_vote_ctrl: RTL and testbench

//  Sequencer for the KNN colour-vote datapath. Per pixel block it sweeps the colour dictionary KNN times
//  (one sweep per sub-block), drives the minimum-search/vote strobes, then triggers the max-count search.
//  It captures the winning colour index and hands it downstream with a valid/ready handshake.

---
 rtl/knn_vote_ctrl.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_knn_vote_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/knn_vote_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : knn_vote_ctrl
// Purpose  : Sequencer for the KNN colour-vote datapath. For every pixel block
//            it sweeps the colour dictionary once per sub-block (KNN sweeps).
//            It drives the minimum-search / vote strobes and then triggers the
//            max-count search. The winning colour index is captured and handed
//            downstream over a valid/ready handshake.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   KNN        sub-blocks (dictionary sweeps) voted per pixel block, 1..63
//   COLOR_NUM  dictionary entries per sweep, 2..8
//   DIST_LAT   cycles from m_addr to valid distance at the vote engine, 0..7
// Optional feature
//   KNN_TIMEOUT_EN  adds a 12-bit FIN watchdog. After 4095 cycles without
//                   out_flag, error colour 4'hF is reported.
// Ports
//   clk_en       in   clock
//   reset_n      in   synchronous active-low reset
//   start        in   begin a pixel block (ignored while busy)
//   blk_valid    in   sub-block pixels loaded into the distance unit
//   blk_next     out  1-cycle request for the next sub-block load
//   m_addr[2:0]  out  dictionary index to distance unit / colour ROM
//   dic_go       out  sweep-active strobe aligned with m
//   m[2:0]       out  dictionary index aligned with distance at vote engine
//   dic_end      out  end-of-sweep flag (aligned)
//   dic_end_q    out  dic_end delayed one cycle
//   knn_fin      out  all sweeps voted, start max search
//   vote_clr_n   out  active-low 1-cycle vote-engine clear, gated with reset_n
//   out_flag     in   max search complete
//   knn_resultf  in   winning colour index from the vote engine
//   res_valid    out  result available
//   res_color    out  captured winning colour index
//   res_ready    in   downstream accepts result
//   busy         out  block in progress
// ============================================================================
module knn_vote_ctrl #(
  parameter int KNN       = 4,
  parameter int COLOR_NUM = 5,
  parameter int DIST_LAT  = 2
) (
  input  logic       clk_en,
  input  logic       reset_n,
  input  logic       start,
  input  logic       blk_valid,
  output logic       blk_next,
  output logic [2:0] m_addr,
  output logic       dic_go,
  output logic [2:0] m,
  output logic       dic_end,
  output logic       dic_end_q,
  output logic       knn_fin,
  output logic       vote_clr_n,
  input  logic       out_flag,
  input  logic [3:0] knn_resultf,
  output logic       res_valid,
  output logic [3:0] res_color,
  input  logic       res_ready,
  output logic       busy
);

  localparam logic [5:0] c_knn    = 6'(KNN);
  localparam logic [2:0] c_m_last = 3'(COLOR_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_BLK = 3'd1,
    S_SCAN     = 3'd2,
    S_END1     = 3'd3,
    S_END2     = 3'd4,
    S_FIN      = 3'd5,
    S_HOLD     = 3'd6,
    S_CLR      = 3'd7
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [5:0] r_sb, w_sb_nxt;
  logic [5:0] w_sb_inc;
  logic [2:0] r_m_addr, w_m_addr_nxt;
  logic       r_res_valid, w_res_valid_nxt;
  logic [3:0] r_res_color, w_res_color_nxt;
  logic       w_blk_next;

  // Undelayed sweep strobes, derived from registered state / address
  logic       w_raw_go, w_raw_end;
  logic [2:0] w_raw_m;

  // Strobes after the distance-latency alignment pipe
  logic       w_dic_go, w_dic_end;
  logic [2:0] w_m;
  logic       r_dic_end_q;
  logic       w_pipe_busy;
  logic       w_knn_fin;
  logic       w_timeout;

  assign w_raw_go  = (r_state == S_SCAN) || (r_state == S_END1) || (r_state == S_END2);
  assign w_raw_end = (r_state == S_END1) || (r_state == S_END2);
  assign w_raw_m   = r_m_addr;
  assign w_sb_inc  = r_sb + 6'd1;

  // --------------------------------------------------------------------------
  // Alignment pipe: go/end/m are delayed so that they reach the vote engine
  // together with the distance computed for the same dictionary index.
  // --------------------------------------------------------------------------
  generate
    if (DIST_LAT == 0) begin : g_pipe_bypass
      assign w_dic_go    = w_raw_go;
      assign w_dic_end   = w_raw_end;
      assign w_m         = w_raw_m;
      assign w_pipe_busy = w_dic_go | w_dic_end | r_dic_end_q;
    end else begin : g_pipe_shift
      logic [DIST_LAT-1:0]      r_go_pipe;
      logic [DIST_LAT-1:0]      r_end_pipe;
      logic [DIST_LAT-1:0][2:0] r_m_pipe;

      always_ff @(posedge clk_en) begin
        if (!reset_n) begin
          r_go_pipe  <= '0;
          r_end_pipe <= '0;
          r_m_pipe   <= '0;
        end else begin
          r_go_pipe[0]  <= w_raw_go;
          r_end_pipe[0] <= w_raw_end;
          r_m_pipe[0]   <= w_raw_m;
          for (int i = 1; i < DIST_LAT; i++) begin
            r_go_pipe[i]  <= r_go_pipe[i-1];
            r_end_pipe[i] <= r_end_pipe[i-1];
            r_m_pipe[i]   <= r_m_pipe[i-1];
          end
        end
      end

      assign w_dic_go    = r_go_pipe[DIST_LAT-1];
      assign w_dic_end   = r_end_pipe[DIST_LAT-1];
      assign w_m         = r_m_pipe[DIST_LAT-1];
      // end implies go, so the go stages cover every in-flight end as well
      assign w_pipe_busy = (|r_go_pipe) | r_dic_end_q;
    end
  endgenerate

  always_ff @(posedge clk_en) begin
    if (!reset_n) begin
      r_dic_end_q <= 1'b0;
    end else begin
      r_dic_end_q <= w_dic_end;
    end
  end

  // Max search may only start once the last vote (dic_end & dic_end_q) is out
  assign w_knn_fin = (r_state == S_FIN) && !w_pipe_busy;

  // --------------------------------------------------------------------------
  // Optional FIN watchdog
  // --------------------------------------------------------------------------
`ifdef KNN_TIMEOUT_EN
  logic [11:0] r_wdog;

  // Held at zero outside FIN, so it starts from zero on every FIN entry
  always_ff @(posedge clk_en) begin
    if (!reset_n || (r_state != S_FIN)) begin
      r_wdog <= '0;
    end else if (r_wdog != 12'hFFF) begin
      r_wdog <= r_wdog + 12'd1;
    end
  end

  assign w_timeout = (r_state == S_FIN) && (r_wdog == 12'hFFF);
`else
  assign w_timeout = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_en) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_sb        <= '0;
      r_m_addr    <= '0;
      r_res_valid <= 1'b0;
      r_res_color <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sb        <= w_sb_nxt;
      r_m_addr    <= w_m_addr_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_res_color <= w_res_color_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state / outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_sb_nxt        = r_sb;
    w_m_addr_nxt    = '0;          // address parks at 0 outside a sweep
    w_res_valid_nxt = r_res_valid;
    w_res_color_nxt = r_res_color;
    w_blk_next      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_WAIT_BLK;
          w_sb_nxt    = '0;
          w_blk_next  = 1'b1;
        end
      end
      S_WAIT_BLK: begin
        if (blk_valid) begin
          w_state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        if (r_m_addr == c_m_last) begin
          w_state_nxt  = S_END1;
          w_m_addr_nxt = r_m_addr;
        end else begin
          w_m_addr_nxt = r_m_addr + 3'd1;
        end
      end
      S_END1: begin
        // address holds the last entry for both end cycles
        w_m_addr_nxt = r_m_addr;
        w_state_nxt  = S_END2;
      end
      S_END2: begin
        w_sb_nxt = w_sb_inc;
        if (w_sb_inc == c_knn) begin
          w_state_nxt = S_FIN;
        end else begin
          w_state_nxt = S_WAIT_BLK;
          w_blk_next  = 1'b1;
        end
      end
      S_FIN: begin
        if (w_knn_fin && out_flag) begin
          w_res_color_nxt = knn_resultf;
          w_res_valid_nxt = 1'b1;
          w_state_nxt     = S_HOLD;
        end else if (w_timeout) begin
          w_res_color_nxt = 4'hF;
          w_res_valid_nxt = 1'b1;
          w_state_nxt     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          w_res_valid_nxt = 1'b0;
          w_state_nxt     = S_CLR;
        end
      end
      S_CLR: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output drive
  // --------------------------------------------------------------------------
  assign blk_next   = w_blk_next & reset_n;
  assign m_addr     = r_m_addr;
  assign dic_go     = w_dic_go;
  assign m          = w_m;
  assign dic_end    = w_dic_end;
  assign dic_end_q  = r_dic_end_q;
  assign knn_fin    = w_knn_fin;
  assign vote_clr_n = reset_n & (r_state != S_CLR);
  assign res_valid  = r_res_valid;
  assign res_color  = r_res_color;
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_knn_vote_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_knn_vote_ctrl
// Purpose  : Self-checking bench for knn_vote_ctrl with default parameters
//            (KNN=4, COLOR_NUM=5, DIST_LAT=2). A table of block scenarios is
//            replayed. Hand-written sequences cover reset and the watchdog.
// Revision : 1.0  initial release
// ============================================================================
module tb_knn_vote_ctrl;

  logic       clk_en = 1'b0;
  logic       reset_n;
  logic       start;
  logic       blk_valid;
  logic       blk_next;
  logic [2:0] m_addr;
  logic       dic_go;
  logic [2:0] m;
  logic       dic_end;
  logic       dic_end_q;
  logic       knn_fin;
  logic       vote_clr_n;
  logic       out_flag;
  logic [3:0] knn_resultf;
  logic       res_valid;
  logic [3:0] res_color;
  logic       res_ready;
  logic       busy;

  knn_vote_ctrl #(.KNN(4), .COLOR_NUM(5), .DIST_LAT(2)) dut (
    .clk_en      (clk_en),
    .reset_n     (reset_n),
    .start       (start),
    .blk_valid   (blk_valid),
    .blk_next    (blk_next),
    .m_addr      (m_addr),
    .dic_go      (dic_go),
    .m           (m),
    .dic_end     (dic_end),
    .dic_end_q   (dic_end_q),
    .knn_fin     (knn_fin),
    .vote_clr_n  (vote_clr_n),
    .out_flag    (out_flag),
    .knn_resultf (knn_resultf),
    .res_valid   (res_valid),
    .res_color   (res_color),
    .res_ready   (res_ready),
    .busy        (busy)
  );

  always #5 clk_en = ~clk_en;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  // Sampled 2 time units after each falling edge, after the stimulus settles.
  int         mon_votes = 0;
  int         mon_blk   = 0;
  int         mon_clr   = 0;
  int         mon_err   = 0;
  int         go_idx    = 0;
  logic [2:0] ma_h1     = 3'd0;
  logic [2:0] ma_h2     = 3'd0;

  always @(negedge clk_en) begin
    #2;
    if (!reset_n) begin
      go_idx = 0;
      ma_h1  = 3'd0;
      ma_h2  = 3'd0;
    end else begin
      if (blk_next) mon_blk++;
      if (!vote_clr_n) mon_clr++;
      if (dic_end && dic_end_q) begin
        mon_votes++;
        if (m != 3'd4) mon_err++;
      end
      if (dic_go) begin
        // each aligned sweep: m = 0,1,2,3,4,4,4 and equals m_addr of 2 cycles ago
        if (m != ((go_idx < 5) ? 3'(go_idx) : 3'd4)) mon_err++;
        if (m != ma_h2) mon_err++;
        go_idx++;
      end else begin
        if (go_idx != 0 && go_idx != 7) mon_err++;
        go_idx = 0;
      end
      if (m_addr > 3'd4) mon_err++;
      ma_h2 = ma_h1;
      ma_h1 = m_addr;
    end
  end

  // ---------------------------------------------------------- vector table
  typedef struct {
    logic [3:0] color;    // knn_resultf returned by the vote model
    int         vdly;     // cycles from knn_fin to out_flag
    int         rdy;      // cycles res_ready is withheld (0: already high)
    int         hold;     // cycles blk_valid withheld before sweep 2
    bit         poke;     // pulse start during sweep 1 scan
    int         exp_lat;  // falling edges from busy rising to knn_fin
  } vec_t;

  vec_t vecs[5];

  task automatic run_block(input vec_t v, input string tag);
    int lat, hold_rem, bad, n;
    bit held, poked;
    mon_votes = 0; mon_blk = 0; mon_clr = 0; mon_err = 0;
    held = 0; poked = 0; hold_rem = 0;
    start = 1'b1;
    @(negedge clk_en);
    start = 1'b0;
    chk({tag, "_busy_start"}, int'(busy), 1);
    lat = 0;
    while (!knn_fin && lat < 400) begin
      @(negedge clk_en);
      lat++;
      if (start) start = 1'b0;
      if (v.hold > 0 && !held && mon_blk >= 2) begin
        blk_valid = 1'b0;
        held      = 1;
        hold_rem  = v.hold;
      end else if (hold_rem > 0) begin
        hold_rem--;
        if (hold_rem == 0) begin
          if (v.hold >= 3) chk({tag, "_dic_go_waiting"}, int'(dic_go), 0);
          blk_valid = 1'b1;
        end
      end
      if (v.poke && !poked && m_addr == 3'd2) begin
        start = 1'b1;
        poked = 1;
      end
    end
    chk({tag, "_knn_fin_latency"}, lat, v.exp_lat);
    bad = 0;
    for (int i = 0; i < v.vdly; i++) begin
      @(negedge clk_en);
      if (!knn_fin || res_valid) bad++;
    end
    chk({tag, "_knn_fin_held"}, bad, 0);
    out_flag    = 1'b1;
    knn_resultf = v.color;
    res_ready   = (v.rdy == 0);
    @(negedge clk_en);
    out_flag    = 1'b0;
    knn_resultf = 4'h0;
    chk({tag, "_res_valid"}, int'(res_valid), 1);
    chk({tag, "_res_color"}, int'(res_color), int'(v.color));
    chk({tag, "_knn_fin_drop"}, int'(knn_fin), 0);
    if (v.rdy > 0) begin
      bad = 0;
      for (int i = 0; i < v.rdy; i++) begin
        @(negedge clk_en);
        if (!res_valid || res_color != v.color || !vote_clr_n) bad++;
      end
      chk({tag, "_res_stable"}, bad, 0);
    end
    res_ready = 1'b1;
    @(negedge clk_en);
    res_ready = 1'b0;
    chk({tag, "_clr_low"}, int'(vote_clr_n), 0);
    chk({tag, "_res_valid_drop"}, int'(res_valid), 0);
    @(negedge clk_en);
    chk({tag, "_clr_high"}, int'(vote_clr_n), 1);
    chk({tag, "_busy_end"}, int'(busy), 0);
    chk({tag, "_votes"}, mon_votes, 4);
    chk({tag, "_blk_next"}, mon_blk, 4);
    chk({tag, "_clr_cycles"}, mon_clr, 1);
    chk({tag, "_stream_err"}, mon_err, 0);
    if (v.poke) begin
      n = 0;
      repeat (10) begin
        @(negedge clk_en);
        if (busy || res_valid) n++;
      end
      chk({tag, "_no_second_block"}, n, 0);
    end
  endtask

  initial begin
    int n;
    vec_t plain;
    //               color  vdly rdy hold poke lat
    vecs[0] = '{4'd3,  6, 10,  0, 1'b0, 35};
    vecs[1] = '{4'd7,  0,  0,  0, 1'b1, 35};
    vecs[2] = '{4'd12, 2,  3, 20, 1'b0, 55};
    vecs[3] = '{4'd15, 1,  1,  1, 1'b0, 36};
    vecs[4] = '{4'd0,  3,  0,  5, 1'b0, 40};
    plain   = '{4'd9,  4,  2,  0, 1'b0, 35};

    reset_n = 1'b0; start = 1'b0; blk_valid = 1'b1;
    out_flag = 1'b0; res_ready = 1'b0; knn_resultf = 4'h0;
    repeat (3) @(negedge clk_en);
    reset_n = 1'b1;
    @(negedge clk_en);

    // reset state
    chk("rst_busy",       int'(busy),       0);
    chk("rst_blk_next",   int'(blk_next),   0);
    chk("rst_m_addr",     int'(m_addr),     0);
    chk("rst_dic_go",     int'(dic_go),     0);
    chk("rst_m",          int'(m),          0);
    chk("rst_dic_end",    int'(dic_end),    0);
    chk("rst_dic_end_q",  int'(dic_end_q),  0);
    chk("rst_knn_fin",    int'(knn_fin),    0);
    chk("rst_vote_clr_n", int'(vote_clr_n), 1);
    chk("rst_res_valid",  int'(res_valid),  0);
    chk("rst_res_color",  int'(res_color),  0);

    // table-driven blocks
    for (int i = 0; i < 5; i++) begin
      run_block(vecs[i], $sformatf("vec%0d", i));
    end

    // reset during END1 of sweep 3
    mon_votes = 0; mon_blk = 0; mon_err = 0;
    start = 1'b1;
    @(negedge clk_en);
    start = 1'b0;
    n = 0;
    while (mon_blk < 3 && n < 200) begin @(negedge clk_en); n++; end
    while (m_addr != 3'd4 && n < 200) begin @(negedge clk_en); n++; end
    chk("mid_rst_reach_sweep3", int'(n < 200), 1);
    @(negedge clk_en);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_clr_same_cycle", int'(vote_clr_n), 0);
    @(negedge clk_en);
    reset_n = 1'b1;
    #1;
    chk("mid_rst_busy",       int'(busy),       0);
    chk("mid_rst_dic_go",     int'(dic_go),     0);
    chk("mid_rst_dic_end",    int'(dic_end),    0);
    chk("mid_rst_dic_end_q",  int'(dic_end_q),  0);
    chk("mid_rst_m_addr",     int'(m_addr),     0);
    chk("mid_rst_m",          int'(m),          0);
    chk("mid_rst_knn_fin",    int'(knn_fin),    0);
    chk("mid_rst_res_valid",  int'(res_valid),  0);
    chk("mid_rst_vote_clr_n", int'(vote_clr_n), 1);
    chk("mid_rst_votes",      mon_votes,        2);
    chk("mid_rst_stream_err", mon_err,          0);
    @(negedge clk_en);
    run_block(plain, "after_rst");

`ifdef KNN_TIMEOUT_EN
    // watchdog: out_flag never arrives
    start = 1'b1;
    @(negedge clk_en);
    start = 1'b0;
    n = 0;
    while (!knn_fin && n < 400) begin @(negedge clk_en); n++; end
    chk("wd_knn_fin_latency", n, 35);
    n = 0;
    while (!res_valid && n < 5000) begin @(negedge clk_en); n++; end
    chk("wd_latency", n, 4093);
    chk("wd_res_color", int'(res_color), 15);
    res_ready = 1'b1;
    @(negedge clk_en);
    res_ready = 1'b0;
    chk("wd_clr_low", int'(vote_clr_n), 0);
    @(negedge clk_en);
    chk("wd_busy_end", int'(busy), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
